// File: rtl/dmux_seq_pkg.sv
// dmux_seq_pkg: shared types and sizes for the demux bit sequencer.
package dmux_seq_pkg;
   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;
   localparam int GAP_W  = 4;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
endpackage

// File: rtl/dmux_bit_sequencer.sv
// dmux_bit_sequencer: serialises a byte onto a 1-to-8 demux in/sel pair, one bit per clock.
// Define DMUX_SEQ_MSB_FIRST_EN for MSB-first slot order (default LSB-first).
module dmux_bit_sequencer
   import dmux_seq_pkg::*;
#(
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             dmux_in,
   output logic [SEL_W-1:0] dmux_sel,
   output logic             dmux_en,
   output logic             busy,
   output logic             frame_done
);
`ifdef DMUX_SEQ_MSB_FIRST_EN
   localparam logic [SEL_W-1:0] FIRST = SEL_W'(NUM_CH - 1);
   localparam logic [SEL_W-1:0] LAST  = '0;
   localparam logic [SEL_W-1:0] STEP  = '1;
`else
   localparam logic [SEL_W-1:0] FIRST = '0;
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_CH - 1);
   localparam logic [SEL_W-1:0] STEP  = SEL_W'(1);
`endif
   state_t             state;
   logic [NUM_CH-1:0]  shreg;
   logic [SEL_W-1:0]   idx;
   logic [GAP_W-1:0]   cnt;
   logic [SEL_W-1:0]   nxt;
   assign nxt = idx + STEP;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         idx        <= '0;
         cnt        <= '0;
         s_ready    <= 1'b0;
         dmux_in    <= 1'b0;
         dmux_sel   <= '0;
         dmux_en    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (s_valid && s_ready) begin
                  state      <= SHIFT;
                  shreg      <= s_data;
                  idx        <= FIRST;
                  s_ready    <= 1'b0;
                  busy       <= 1'b1;
                  dmux_en    <= 1'b1;
                  dmux_sel   <= FIRST;
                  dmux_in    <= s_data[FIRST];
                  frame_done <= 1'b0;
               end else
                  s_ready <= 1'b1;
            SHIFT:
               if (idx == LAST) begin
                  dmux_en    <= 1'b0;
                  dmux_sel   <= '0;
                  dmux_in    <= 1'b0;
                  frame_done <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     state <= GAP;
                     cnt   <= GAP_W'(GAP_CYCLES - 1);
                  end else begin
                     state   <= IDLE;
                     s_ready <= 1'b1;
                     busy    <= 1'b0;
                  end
               end else begin
                  idx        <= nxt;
                  dmux_sel   <= nxt;
                  dmux_in    <= shreg[nxt];
                  frame_done <= (nxt == LAST);
               end
            GAP:
               if (cnt == '0) begin
                  state   <= IDLE;
                  s_ready <= 1'b1;
                  busy    <= 1'b0;
               end else
                  cnt <= cnt - 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_dmux_bit_sequencer.sv
// tb_dmux_bit_sequencer: checks two instances (gap 1 and gap 0) against a timeline model.
module tb_dmux_bit_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] sv = '0, rdy_o, in_o, en_o, busy_o, fd_o;
   logic [1:0][7:0] sd = '0;
   logic [1:0][2:0] sel_o;
   int vectors = 0, errs = 0, cyc = 0;
   int t [2];
   int gapv [2];
   logic mrdy [2];
   logic acc [2];
   logic [7:0] mb [2];
   logic [7:0] q0 [$], q1 [$];
   int acc0 [$], acc1 [$];
   logic [7:0] lines;

   always #5 clk = ~clk;

   dmux_bit_sequencer #(.GAP_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .s_data(sd[0]), .s_valid(sv[0]), .s_ready(rdy_o[0]),
      .dmux_in(in_o[0]), .dmux_sel(sel_o[0]), .dmux_en(en_o[0]), .busy(busy_o[0]),
      .frame_done(fd_o[0]));
   dmux_bit_sequencer #(.GAP_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .s_data(sd[1]), .s_valid(sv[1]), .s_ready(rdy_o[1]),
      .dmux_in(in_o[1]), .dmux_sel(sel_o[1]), .dmux_en(en_o[1]), .busy(busy_o[1]),
      .frame_done(fd_o[1]));

   // slot k of a frame drives demux line pos(k)
   function automatic int pos(int k);
`ifdef DMUX_SEQ_MSB_FIRST_EN
      return 7 - k;
`else
      return k;
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         t[d] = -1;
         mrdy[d] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         logic act;
         int p;
         act = (t[d] >= 0) && (t[d] < 8);
         p = act ? pos(t[d]) : 0;
         chk($sformatf("ready%0d@%0d", d, cyc), rdy_o[d], mrdy[d]);
         chk($sformatf("en%0d@%0d", d, cyc), en_o[d], act);
         chk($sformatf("sel%0d@%0d", d, cyc), sel_o[d], act ? p : 0);
         chk($sformatf("in%0d@%0d", d, cyc), in_o[d], act ? mb[d][p] : 1'b0);
         chk($sformatf("frame_done%0d@%0d", d, cyc), fd_o[d], t[d] == 7);
         chk($sformatf("busy%0d@%0d", d, cyc), busy_o[d], t[d] >= 0);
      end
   endtask

   task automatic apply();
      sv[0] = q0.size() > 0;
      sd[0] = sv[0] ? q0[0] : 8'h00;
      sv[1] = q1.size() > 0;
      sd[1] = sv[1] ? q1[0] : 8'h00;
   endtask

   task automatic step();
      for (int d = 0; d < 2; d++) acc[d] = sv[d] && mrdy[d];
      @(posedge clk);
      cyc++;
      if (!rst)
         for (int d = 0; d < 2; d++)
            if (acc[d]) begin
               t[d] = 0;
               mb[d] = sd[d];
               mrdy[d] = 1'b0;
            end else if (t[d] >= 0) begin
               t[d]++;
               if (t[d] >= 8 + gapv[d]) begin
                  t[d] = -1;
                  mrdy[d] = 1'b1;
               end
            end else
               mrdy[d] = 1'b1;
      #1;
      if (en_o[0]) lines[sel_o[0]] = lines[sel_o[0]] | in_o[0];
      check_all();
      if (!rst && acc[0]) begin
         acc0.push_back(cyc);
         void'(q0.pop_front());
      end
      if (!rst && acc[1]) begin
         acc1.push_back(cyc);
         void'(q1.pop_front());
      end
      apply();
   endtask

   initial begin
      gapv[0] = 1;
      gapv[1] = 0;
      model_reset();
      #1;
      check_all();
      repeat (3) step();
      rst = 1'b0;
      step();
      // single byte, demux lines touched must equal the byte
      lines = 8'h00;
      q0.push_back(8'hA5);
      apply();
      repeat (9) step();
      chk("a5_lines", lines, 8'hA5);
      q0.push_back(8'h01);
      apply();
      repeat (12) step();
      // back-to-back with valid held: gap-1 and gap-0 spacing
      acc0.delete();
      acc1.delete();
      q0.push_back(8'hFF);
      q0.push_back(8'h00);
      q1.push_back(8'h3C);
      q1.push_back(8'hC3);
      q1.push_back(8'h5A);
      apply();
      repeat (40) step();
      chk("b2b_count_g1", acc0.size(), 2);
      chk("b2b_count_g0", acc1.size(), 3);
      if (acc0.size() == 2) chk("b2b_space_g1", acc0[1] - acc0[0], 10);
      if (acc1.size() == 3) begin
         chk("b2b_space_g0_a", acc1[1] - acc1[0], 9);
         chk("b2b_space_g0_b", acc1[2] - acc1[1], 9);
      end
      // reset in the sel=3 slot
      q0.push_back(8'hFF);
      apply();
      repeat (4) step();
      chk("pre_rst_sel", sel_o[0], pos(3));
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      repeat (2) step();
      rst = 1'b0;
      q0.push_back(8'h0F);
      apply();
      repeat (14) step();
      // random traffic
      for (int i = 0; i < 400; i++) begin
         if (q0.size() == 0 && $urandom_range(3) == 0) q0.push_back(8'($urandom));
         if (q1.size() == 0 && $urandom_range(3) == 0) q1.push_back(8'($urandom));
         apply();
         step();
      end
      repeat (30) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
